// File: rtl/dbg_ocimem_pkg.sv
// Shared types and jdo field positions for the debug on-chip memory controller.
package dbg_ocimem_pkg;

  localparam int DATA_W       = 32;
  localparam int JDO_RD_BIT   = 34;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_ADDR_LSB = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_JRD,
    ST_JRD_CAP,
    ST_JWR,
    ST_ARD,
    ST_ARD_CAP
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

endpackage

// File: rtl/dbg_ocimem_ctrl_if.sv
// CPU-side Avalon debug_mem_slave signals of the debug RAM controller.
interface dbg_ocimem_ctrl_if
  import dbg_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [3:0]        avs_byteenable;
  logic              avs_debugaccess;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_debugaccess,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_debugaccess,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/dbg_ocimem_ram.sv
// Byte-enabled synchronous single-port debug RAM, one cycle read latency,
// read-before-write. Contents are deliberately not reset.
module dbg_ocimem_ram
  import dbg_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Byte-lane write and registered read of the addressed word
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dbg_ocimem_ctrl.sv
// Debug on-chip memory controller: executes JTAG (jdo) reads/writes into the
// debug RAM and arbitrates that RAM with the CPU Avalon debug_mem_slave port.
// Optional build macro: DBG_OCIMEM_WRPROT_EN -- Avalon writes without
// avs_debugaccess are acknowledged but do not modify the RAM.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | arbitrate; Avalon writes complete here in one cycle
// ST_JRD     | RAM read at MonAReg for a JTAG read
// ST_JRD_CAP | MonDReg takes RAM data, JTAG op retires
// ST_JWR     | RAM write of MonDReg at MonAReg, JTAG op retires
// ST_ARD     | RAM data for the Avalon read lands in the readdata register
// ST_ARD_CAP | Avalon read acknowledged (waitrequest low)
module dbg_ocimem_ctrl
  import dbg_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int JDO_W  = 38
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [JDO_W-1:0]     jdo,
  input  logic                 take_action_ocimem_a,
  input  logic                 take_action_ocimem_b,
  input  logic                 take_no_action_ocimem_a,
  dbg_ocimem_ctrl_if.slave     avs,
  output logic [DATA_W-1:0]    MonDReg,
  output logic                 ocimem_busy,
  output logic                 ocimem_overrun
);

  state_t            state, state_n;
  op_t               op;
  logic              jtag_pend;
  logic              rd_inc;
  logic [ADDR_W-1:0] mon_a_reg;
  logic [DATA_W-1:0] rd_q;

  logic              strobe_any, accept, new_op, new_wr, new_inc, clr_pend;
  logic              wait_req, wr_commit;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LSB-1:0]};

  // An address-only action_a (read bit clear) just loads MonAReg and queues no work.
  assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign accept     = strobe_any & ~jtag_pend;
  assign new_op     = accept & (take_action_ocimem_a ? jdo[JDO_RD_BIT] : 1'b1);
  assign new_wr     = ~take_action_ocimem_a & take_action_ocimem_b;
  assign new_inc    = ~take_action_ocimem_a & ~take_action_ocimem_b & take_no_action_ocimem_a;

`ifdef DBG_OCIMEM_WRPROT_EN
  assign wr_commit = avs.avs_debugaccess;
`else
  logic unused_dbgacc;
  assign unused_dbgacc = avs.avs_debugaccess;
  assign wr_commit     = 1'b1;
`endif

  assign ocimem_busy         = jtag_pend | (state == ST_JRD) | (state == ST_JRD_CAP) | (state == ST_JWR);
  assign avs.avs_waitrequest = wait_req;
  assign avs.avs_readdata    = rd_q;

  dbg_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Arbiter state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next state, RAM port mux and Avalon handshake
  always_comb begin
    state_n   = state;
    ram_addr  = avs.avs_address;
    ram_we    = 1'b0;
    ram_be    = avs.avs_byteenable;
    ram_wdata = avs.avs_writedata;
    wait_req  = 1'b1;
    clr_pend  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (jtag_pend) begin
          state_n = (op == OP_WR) ? ST_JWR : ST_JRD;
        end else if (!new_op) begin
          // A JTAG op being captured this cycle beats a simultaneous Avalon request.
          if (avs.avs_read) begin
            state_n = ST_ARD;
          end else if (avs.avs_write) begin
            wait_req = 1'b0;
            ram_we   = wr_commit;
          end
        end
      end
      ST_JRD: begin
        ram_addr = mon_a_reg;
        state_n  = ST_JRD_CAP;
      end
      ST_JRD_CAP: begin
        clr_pend = 1'b1;
        state_n  = ST_IDLE;
      end
      ST_JWR: begin
        ram_addr  = mon_a_reg;
        ram_we    = 1'b1;
        ram_be    = 4'hF;
        ram_wdata = MonDReg;
        clr_pend  = 1'b1;
        state_n   = ST_IDLE;
      end
      ST_ARD: begin
        state_n = ST_ARD_CAP;
      end
      ST_ARD_CAP: begin
        wait_req = 1'b0;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // JTAG strobe capture, pending flag and sticky overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jtag_pend      <= 1'b0;
      op             <= OP_RD;
      rd_inc         <= 1'b0;
      ocimem_overrun <= 1'b0;
    end else begin
      if (strobe_any && jtag_pend)  ocimem_overrun <= 1'b1;
      else if (take_action_ocimem_a) ocimem_overrun <= 1'b0;
      if (clr_pend) begin
        jtag_pend <= 1'b0;
      end else if (new_op) begin
        jtag_pend <= 1'b1;
        op        <= new_wr ? OP_WR : OP_RD;
        rd_inc    <= new_inc;
      end
    end
  end

  // MonAReg / MonDReg / Avalon readdata datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_a_reg <= '0;
      MonDReg   <= '0;
      rd_q      <= '0;
    end else begin
      if (state == ST_JRD_CAP) begin
        MonDReg <= ram_rdata;
        if (rd_inc) mon_a_reg <= mon_a_reg + ADDR_W'(1);
      end else if (state == ST_JWR) begin
        mon_a_reg <= mon_a_reg + ADDR_W'(1);
      end else if (accept && take_action_ocimem_a) begin
        mon_a_reg <= jdo[JDO_ADDR_LSB +: ADDR_W];
      end else if (accept && take_action_ocimem_b) begin
        MonDReg <= jdo[JDO_DATA_LSB +: DATA_W];
      end
      // Loaded here so the data is already valid while waitrequest is low.
      if (state == ST_ARD) rd_q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_dbg_ocimem_ctrl.sv
// Directed bench for dbg_ocimem_ctrl: JTAG write/read, wrap, arbitration,
// overrun, Avalon byte enables / write protection, reset abort.
module tb_dbg_ocimem_ctrl;

  localparam int ADDR_W = 8;
  localparam int JDO_W  = 38;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [JDO_W-1:0] jdo = '0;
  logic             ta_a = 1'b0, ta_b = 1'b0, tna_a = 1'b0;
  logic [31:0]      MonDReg;
  logic             ocimem_busy, ocimem_overrun;

  int n_cmp = 0;
  int n_mis = 0;

  dbg_ocimem_ctrl_if #(.ADDR_W(ADDR_W)) avs ();

  dbg_ocimem_ctrl #(.ADDR_W(ADDR_W), .JDO_W(JDO_W)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tna_a),
    .avs                     (avs),
    .MonDReg                 (MonDReg),
    .ocimem_busy             (ocimem_busy),
    .ocimem_overrun          (ocimem_overrun)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [JDO_W-1:0] jdo_a(input logic [7:0] a, input logic rd);
    logic [JDO_W-1:0] v;
    v        = '0;
    v[24:17] = a;
    v[34]    = rd;
    return v;
  endfunction

  function automatic logic [JDO_W-1:0] jdo_b(input logic [31:0] d);
    logic [JDO_W-1:0] v;
    v       = '0;
    v[34:3] = d;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // kind: 0 = take_action_a, 1 = take_action_b, 2 = take_no_action_a
  task automatic jstrobe(input int kind, input logic [JDO_W-1:0] j);
    jdo = j;
    case (kind)
      0:       ta_a  = 1'b1;
      1:       ta_b  = 1'b1;
      default: tna_a = 1'b1;
    endcase
    tick();
    ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ocimem_busy && n < 50) begin
      tick();
      n++;
    end
    if (ocimem_busy) check_val("idle_timeout", 32'(ocimem_busy), 32'd0);
  endtask

  task automatic avs_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, input logic da);
    avs.avs_address     = a;
    avs.avs_writedata   = d;
    avs.avs_byteenable  = be;
    avs.avs_debugaccess = da;
    avs.avs_write       = 1'b1;
    #1;
    check_val("avs_wr_accept", 32'(avs.avs_waitrequest), 32'd0);
    tick();
    avs.avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [7:0] a, output logic [31:0] d);
    int lat;
    avs.avs_address = a;
    avs.avs_read    = 1'b1;
    #1;
    lat = 0;
    while (avs.avs_waitrequest && lat < 20) begin
      lat++;
      tick();
    end
    check_val("avs_rd_latency", 32'(lat), 32'd2);
    d = avs.avs_readdata;
    tick();
    avs.avs_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          n;

    avs.avs_address = '0; avs.avs_read = 1'b0; avs.avs_write = 1'b0;
    avs.avs_writedata = '0; avs.avs_byteenable = 4'hF; avs.avs_debugaccess = 1'b1;

    // reset values
    repeat (3) tick();
    check_val("rst_mond",    MonDReg, 32'h0);
    check_val("rst_mona",    32'(dut.mon_a_reg), 32'h0);
    check_val("rst_rdata",   avs.avs_readdata, 32'h0);
    check_val("rst_waitreq", 32'(avs.avs_waitrequest), 32'd1);
    check_val("rst_busy",    32'(ocimem_busy), 32'd0);
    check_val("rst_overrun", 32'(ocimem_overrun), 32'd0);
    reset_n = 1'b1;
    tick();

    // JTAG write: address-only action_a, then action_b
    jstrobe(0, jdo_a(8'h10, 1'b0));
    check_val("addr_only_busy", 32'(ocimem_busy), 32'd0);
    check_val("addr_load", 32'(dut.mon_a_reg), 32'h10);
    jstrobe(1, jdo_b(32'hDEADBEEF));
    n = 0;
    while (ocimem_busy && n < 20) begin
      n++;
      tick();
    end
    check_val("wr_busy_cycles", 32'(n), 32'd2);
    check_val("wr_mona_inc", 32'(dut.mon_a_reg), 32'h11);

    // JTAG read latency: MonDReg changes on the 3rd cycle after the strobe
    jstrobe(1, jdo_b(32'h11111111));
    wait_idle();
    check_val("wr_mona_inc2", 32'(dut.mon_a_reg), 32'h12);
    jstrobe(0, jdo_a(8'h10, 1'b1));
    tick();
    tick();
    check_val("rd_not_yet", MonDReg, 32'h11111111);
    tick();
    check_val("rd_data", MonDReg, 32'hDEADBEEF);
    check_val("rd_busy_done", 32'(ocimem_busy), 32'd0);
    check_val("rd_mona_noinc", 32'(dut.mon_a_reg), 32'h10);

    // MonAReg wrap on write and on no_action read
    jstrobe(0, jdo_a(8'hFF, 1'b0));
    jstrobe(1, jdo_b(32'hCAFEF00D));
    wait_idle();
    check_val("wr_wrap", 32'(dut.mon_a_reg), 32'h0);
    jstrobe(0, jdo_a(8'h10, 1'b1));
    wait_idle();
    check_val("rd_again", MonDReg, 32'hDEADBEEF);
    jstrobe(0, jdo_a(8'hFF, 1'b0));
    jstrobe(2, '0);
    wait_idle();
    check_val("noact_data", MonDReg, 32'hCAFEF00D);
    check_val("noact_wrap", 32'(dut.mon_a_reg), 32'h0);

    // Avalon read and JTAG write strobe in the same cycle: JTAG first
    avs_wr(8'h20, 32'hA5A50020, 4'hF, 1'b1);
    jstrobe(0, jdo_a(8'h30, 1'b0));
    avs.avs_address = 8'h20;
    avs.avs_read    = 1'b1;
    jdo             = jdo_b(32'h0BADF00D);
    ta_b            = 1'b1;
    #1;
    n = 0;
    while (avs.avs_waitrequest && n < 30) begin
      n++;
      tick();
      ta_b = 1'b0;
    end
    check_val("arb_wait_cycles", 32'(n), 32'd5);
    check_val("arb_busy_done", 32'(ocimem_busy), 32'd0);
    check_val("arb_rdata", avs.avs_readdata, 32'hA5A50020);
    tick();
    avs.avs_read = 1'b0;
    check_val("arb_jtag_mona", 32'(dut.mon_a_reg), 32'h31);
    avs_rd(8'h30, rd);
    check_val("arb_jtag_wr", rd, 32'h0BADF00D);

    // Overrun: second consecutive strobe dropped
    jstrobe(0, jdo_a(8'h40, 1'b0));
    jstrobe(1, jdo_b(32'h00000001));
    jstrobe(1, jdo_b(32'h00000002));
    check_val("ovr_set", 32'(ocimem_overrun), 32'd1);
    wait_idle();
    check_val("ovr_mond", MonDReg, 32'h00000001);
    check_val("ovr_mona", 32'(dut.mon_a_reg), 32'h41);
    jstrobe(0, jdo_a(8'h40, 1'b1));
    check_val("ovr_clear", 32'(ocimem_overrun), 32'd0);
    wait_idle();
    check_val("ovr_rd_back", MonDReg, 32'h00000001);
    // action_a colliding with a pending op: set beats clear
    jstrobe(1, jdo_b(32'h00000003));
    jstrobe(0, jdo_a(8'h50, 1'b1));
    check_val("ovr_set_wins", 32'(ocimem_overrun), 32'd1);
    wait_idle();
    check_val("ovr_a_dropped", 32'(dut.mon_a_reg), 32'h41);
    jstrobe(0, jdo_a(8'h40, 1'b0));
    check_val("ovr_clear2", 32'(ocimem_overrun), 32'd0);

    // Avalon write protection and byte enables
    avs_wr(8'h50, 32'hFFFF0000, 4'hF, 1'b1);
    avs_wr(8'h50, 32'h12345678, 4'hF, 1'b0);
    avs_rd(8'h50, rd);
`ifdef DBG_OCIMEM_WRPROT_EN
    check_val("wrprot_nodbg", rd, 32'hFFFF0000);
`else
    check_val("wrprot_nodbg", rd, 32'h12345678);
`endif
    avs_wr(8'h50, 32'h12345678, 4'hF, 1'b1);
    avs_rd(8'h50, rd);
    check_val("wr_dbg", rd, 32'h12345678);
    avs_wr(8'h50, 32'hAABBCCDD, 4'b0101, 1'b1);
    avs_rd(8'h50, rd);
    check_val("wr_byteen", rd, 32'h12BB56DD);

    // Reset in the middle of a JTAG read aborts it, RAM survives
    jstrobe(0, jdo_a(8'h10, 1'b1));
    tick();
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(ocimem_busy), 32'd0);
    check_val("mid_rst_mond", MonDReg, 32'h0);
    check_val("mid_rst_mona", 32'(dut.mon_a_reg), 32'h0);
    check_val("mid_rst_waitreq", 32'(avs.avs_waitrequest), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    avs_rd(8'h10, rd);
    check_val("ram_kept", rd, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
